// File: rtl/display_encode_sequencer.sv
// display_encode_sequencer
//   Frame-level controller for the gamma/colour encoder. For each row it
//   streams pixels from the framebuffer into the encoder and writes the
//   encoded cycle-width values into one bank of a double-buffered line
//   buffer. Completed lines go to the PWM/shift-out stage through a 2-deep
//   valid/ack queue.
//
// Ports
//   clk, reset_n      system clock, asynchronous active-low reset
//   start             1-cycle pulse, begins a frame when idle
//   busy              high from accepted start until the last row is written
//   frame_done        1-cycle pulse on the last row's final line-buffer write
//   fb_rd, fb_addr    framebuffer read request, address = {row, col}
//   fb_data           framebuffer read data, valid the cycle after fb_rd
//   enc_pixel         registered pixel presented to the encoder
//   enc_cpixel        encoder result, valid one cycle after enc_pixel
//   lb_we, lb_bank,
//   lb_addr, lb_data  line-buffer write port
//   line_valid,
//   line_bank,
//   line_row          head of the completed-line queue
//   line_ack          consumer releases the head line
module display_encode_sequencer #(
    parameter int SEGMENTS   = 1,
    parameter int BITWIDTH   = 8,
    parameter int CYCLEWIDTH = 8,
    parameter int COL_BITS   = 6,
    parameter int ROW_BITS   = 5
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               start,
    output logic                               busy,
    output logic                               frame_done,
    output logic                               fb_rd,
    output logic [ROW_BITS+COL_BITS-1:0]       fb_addr,
    input  logic [BITWIDTH*3*SEGMENTS-1:0]     fb_data,
    output logic [BITWIDTH*3*SEGMENTS-1:0]     enc_pixel,
    input  logic [CYCLEWIDTH*3*SEGMENTS-1:0]   enc_cpixel,
    output logic                               lb_we,
    output logic                               lb_bank,
    output logic [COL_BITS-1:0]                lb_addr,
    output logic [CYCLEWIDTH*3*SEGMENTS-1:0]   lb_data,
    output logic                               line_valid,
    output logic                               line_bank,
    output logic [ROW_BITS-1:0]                line_row,
    input  logic                               line_ack
);

    localparam logic [COL_BITS-1:0] COL_LAST = '1;
    localparam logic [ROW_BITS-1:0] ROW_LAST = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        DRAIN     = 2'd2,
        WAIT_BANK = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [COL_BITS-1:0]   col;
    logic [ROW_BITS-1:0]   row;
    logic [1:0]            drain_cnt;
    logic                  wr_bank;
    logic                  push;
    logic                  pop;

    // Completed-line queue
    logic                  q_bank [2];
    logic [ROW_BITS-1:0]   q_row  [2];
    logic                  q_rd;
    logic                  q_wr;
    logic [1:0]            q_cnt;
    logic [1:0]            q_cnt_nxt;

    // Read-return tracking: issue -> fb_data -> enc_pixel -> enc_cpixel
    logic                  vld_p0, vld_p1, vld_p2;
    logic [COL_BITS-1:0]   col_p0, col_p1, col_p2;
    logic                  bank_p0, bank_p1, bank_p2;

    // Queue occupancy after this cycle's push/pop; the stall decisions look
    // at it so that an ack frees the bank for the very next cycle.
    always_comb begin
        q_cnt_nxt = q_cnt;
        case ({push, pop})
            2'b10:   q_cnt_nxt = q_cnt + 2'd1;
            2'b01:   q_cnt_nxt = q_cnt - 2'd1;
            default: q_cnt_nxt = q_cnt;
        endcase
    end

    assign pop = line_ack && (q_cnt != 2'd0);

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // A frame may start with both banks still queued.
                if (start) begin
                    state_nxt = (q_cnt_nxt < 2'd2) ? FILL : WAIT_BANK;
                end
            end
            FILL: begin
                if (col == COL_LAST) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == 2'd2) begin
                    if (row == ROW_LAST) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = (q_cnt_nxt < 2'd2) ? FILL : WAIT_BANK;
                    end
                end
            end
            WAIT_BANK: begin
                if (q_cnt_nxt < 2'd2) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy       = (state != IDLE);
        fb_rd      = (state == FILL);
        push       = (state == DRAIN) && (drain_cnt == 2'd2);
        frame_done = (state == DRAIN) && (drain_cnt == 2'd2) && (row == ROW_LAST);
    end

    assign fb_addr = fb_rd ? {row, col} : '0;

    // Row/column/bank counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col       <= '0;
            row       <= '0;
            drain_cnt <= 2'd0;
            wr_bank   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        col <= '0;
                        row <= '0;
                    end
                    drain_cnt <= 2'd0;
                end
                FILL: begin
                    col       <= col + 1'b1;
                    drain_cnt <= 2'd0;
                end
                DRAIN: begin
                    if (drain_cnt == 2'd2) begin
                        // Row wraps to 0 after the last row, ready for the next frame.
                        drain_cnt <= 2'd0;
                        row       <= row + 1'b1;
                        col       <= '0;
                        wr_bank   <= ~wr_bank;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                default: drain_cnt <= 2'd0;
            endcase
        end
    end

    // Completed-line FIFO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_bank[0] <= 1'b0;
            q_bank[1] <= 1'b0;
            q_row[0]  <= '0;
            q_row[1]  <= '0;
            q_rd      <= 1'b0;
            q_wr      <= 1'b0;
            q_cnt     <= 2'd0;
        end else begin
            if (push) begin
                q_bank[q_wr] <= wr_bank;
                q_row[q_wr]  <= row;
                q_wr         <= ~q_wr;
            end
            if (pop) begin
                q_rd <= ~q_rd;
            end
            q_cnt <= q_cnt_nxt;
        end
    end

    assign line_valid = (q_cnt != 2'd0);
    assign line_bank  = line_valid ? q_bank[q_rd] : 1'b0;
    assign line_row   = line_valid ? q_row[q_rd]  : '0;

    // Stage p0: read issued last cycle, fb_data valid now
    // Stage p1: pixel held in enc_pixel
    // Stage p2: encoder result on enc_cpixel, written to the line buffer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p0 <= fb_rd;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        col_p0  <= col;
        bank_p0 <= wr_bank;
        col_p1  <= col_p0;
        bank_p1 <= bank_p0;
        col_p2  <= col_p1;
        bank_p2 <= bank_p1;
    end

    // enc_pixel is a visible output, so it is cleared on reset; it holds
    // between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enc_pixel <= '0;
        end else if (vld_p0) begin
            enc_pixel <= fb_data;
        end
    end

    assign lb_we   = vld_p2;
    assign lb_addr = vld_p2 ? col_p2  : '0;
    assign lb_bank = vld_p2 ? bank_p2 : 1'b0;
    assign lb_data = enc_cpixel;

endmodule
